// File: rtl/univ_shreg_pkg.sv
// Package for the universal shift register.
// Holds the 2-bit operating-mode encodings and the mode type.
// The top and its per-stage sub-module both import it.
package univ_shreg_pkg;

    typedef logic [1:0] mode_t;

    localparam mode_t MODE_HOLD = 2'b00;
    localparam mode_t MODE_SHR  = 2'b01;
    localparam mode_t MODE_SHL  = 2'b10;
    localparam mode_t MODE_LOAD = 2'b11;

endpackage : univ_shreg_pkg

// File: rtl/shreg_stage.sv
// One stage of the universal shift register.
// The stage is a WIDTH-bit 4:1 mux (hold / right neighbour / left neighbour /
// parallel slice) feeding a flop with synchronous active-low reset.
// Ports:
//   clk      rising-edge clock
//   rstn     synchronous active-low reset
//   sel_i    effective mode; already forced to HOLD by the top when disabled
//   right_i  value taken on a right shift (stage i+1, or the end-stage input)
//   left_i   value taken on a left shift (stage i-1, or the end-stage input)
//   pin_i    parallel load slice
//   q_o      registered stage value
module shreg_stage
    import univ_shreg_pkg::*;
#(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             rstn,
    input  mode_t            sel_i,
    input  logic [WIDTH-1:0] right_i,
    input  logic [WIDTH-1:0] left_i,
    input  logic [WIDTH-1:0] pin_i,
    output logic [WIDTH-1:0] q_o
);

    logic [WIDTH-1:0] stage_d;
    logic [WIDTH-1:0] stage_q;

    // Next-value mux for this stage.
    always_comb begin
        stage_d = stage_q;
        case (sel_i)
            MODE_SHR:  stage_d = right_i;
            MODE_SHL:  stage_d = left_i;
            MODE_LOAD: stage_d = pin_i;
            default:   stage_d = stage_q;
        endcase
    end

    // Stage register with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            stage_q <= {WIDTH{1'b0}};
        end else begin
            stage_q <= stage_d;
        end
    end

    assign q_o = stage_q;

endmodule : shreg_stage

// File: rtl/univ_shift_reg.sv
// Universal shift register: DEPTH stages of WIDTH bits with hold, shift
// right, shift left and parallel load; covers SISO, SIPO, PISO and PIPO use.
// A saturating fill counter and full flag track how many stages hold valid
// data since the last reset or load.
// Optional macro UNIV_SHREG_ROTATE_EN adds the rot input: a shift with rot=1
// recirculates the outgoing end stage instead of taking sin and leaves the
// fill counter unchanged.
// Ports:
//   clk       rising-edge clock
//   rstn      synchronous active-low reset (overrides en/mode)
//   en        operation enable; 0 forces hold
//   mode      00 HOLD, 01 SHIFT_RIGHT, 10 SHIFT_LEFT, 11 LOAD
//   rot       (UNIV_SHREG_ROTATE_EN only) rotate on shifts
//   sin       serial input lane
//   pin       parallel data, stage i = pin[i*WIDTH +: WIDTH]
//   sout_r    stage[0] (right-shift serial output)
//   sout_l    stage[DEPTH-1] (left-shift serial output)
//   pout      all stages, stage i at [i*WIDTH +: WIDTH]
//   fill_cnt  valid stages, saturating at DEPTH
//   full      fill_cnt == DEPTH
module univ_shift_reg
    import univ_shreg_pkg::*;
#(
    parameter int WIDTH = 1,
    parameter int DEPTH = 4,
    parameter int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic                   clk,
    input  logic                   rstn,
    input  logic                   en,
    input  logic [1:0]             mode,
`ifdef UNIV_SHREG_ROTATE_EN
    input  logic                   rot,
`endif
    input  logic [WIDTH-1:0]       sin,
    input  logic [WIDTH*DEPTH-1:0] pin,
    output logic [WIDTH-1:0]       sout_r,
    output logic [WIDTH-1:0]       sout_l,
    output logic [WIDTH*DEPTH-1:0] pout,
    output logic [CNT_W-1:0]       fill_cnt,
    output logic                   full
);

    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

    mode_t            eff_mode_s;
    logic             rot_s;
    logic [WIDTH-1:0] shr_in_s;
    logic [WIDTH-1:0] shl_in_s;
    logic [WIDTH-1:0] stage_s [DEPTH];

    logic [CNT_W-1:0] cnt_d;
    logic [CNT_W-1:0] cnt_q;
    logic             full_d;
    logic             full_q;

`ifdef UNIV_SHREG_ROTATE_EN
    assign rot_s = rot;
`else
    assign rot_s = 1'b0;
`endif

    // Disabled operation collapses to HOLD so stages see a single select.
    assign eff_mode_s = en ? mode_t'(mode) : MODE_HOLD;

    // End-stage inputs: rotation feeds back the lane leaving the other end.
    assign shr_in_s = rot_s ? stage_s[0]       : sin;
    assign shl_in_s = rot_s ? stage_s[DEPTH-1] : sin;

    for (genvar i = 0; i < DEPTH; i++) begin : g_stage
        logic [WIDTH-1:0] right_s;
        logic [WIDTH-1:0] left_s;

        if (i == DEPTH - 1) begin : g_right_end
            assign right_s = shr_in_s;
        end else begin : g_right_mid
            assign right_s = stage_s[i+1];
        end

        if (i == 0) begin : g_left_end
            assign left_s = shl_in_s;
        end else begin : g_left_mid
            assign left_s = stage_s[i-1];
        end

        shreg_stage #(
            .WIDTH (WIDTH)
        ) u_stage (
            .clk     (clk),
            .rstn    (rstn),
            .sel_i   (eff_mode_s),
            .right_i (right_s),
            .left_i  (left_s),
            .pin_i   (pin[i*WIDTH +: WIDTH]),
            .q_o     (stage_s[i])
        );

        assign pout[i*WIDTH +: WIDTH] = stage_s[i];
    end

    // Fill counter next state: saturating increment on non-rotating shifts.
    always_comb begin
        cnt_d = cnt_q;
        case (eff_mode_s)
            MODE_SHR, MODE_SHL: begin
                if (rot_s) begin
                    cnt_d = cnt_q;
                end else if (cnt_q < DEPTH_C) begin
                    cnt_d = cnt_q + CNT_W'(1);
                end else begin
                    cnt_d = cnt_q;
                end
            end
            MODE_LOAD: cnt_d = DEPTH_C;
            default:   cnt_d = cnt_q;
        endcase
        full_d = (cnt_d == DEPTH_C);
    end

    // Counter and full flag registers; full is registered so it is a direct flop read.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            cnt_q  <= {CNT_W{1'b0}};
            full_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            full_q <= full_d;
        end
    end

    assign sout_r   = stage_s[0];
    assign sout_l   = stage_s[DEPTH-1];
    assign fill_cnt = cnt_q;
    assign full     = full_q;

endmodule : univ_shift_reg

// File: tb/tb_univ_shift_reg.sv
// Directed testbench for univ_shift_reg.
// DUT a: WIDTH=1, DEPTH=4. DUT b: WIDTH=8, DEPTH=3.
// Define UNIV_SHREG_ROTATE_EN to include the rotate scenario.
module tb_univ_shift_reg;

    logic clk;
    int   tests_run;
    int   tests_failed;

    // DUT a signals
    logic        rstn_a, en_a;
    logic [1:0]  mode_a;
    logic [0:0]  sin_a;
    logic [3:0]  pin_a;
    logic [0:0]  sout_r_a, sout_l_a;
    logic [3:0]  pout_a;
    logic [2:0]  fill_a;
    logic        full_a;

    // DUT b signals
    logic        rstn_b, en_b;
    logic [1:0]  mode_b;
    logic [7:0]  sin_b;
    logic [23:0] pin_b;
    logic [7:0]  sout_r_b, sout_l_b;
    logic [23:0] pout_b;
    logic [1:0]  fill_b;
    logic        full_b;

`ifdef UNIV_SHREG_ROTATE_EN
    logic rot_a, rot_b;
`endif

    univ_shift_reg #(.WIDTH(1), .DEPTH(4)) u_dut_a (
        .clk      (clk),
        .rstn     (rstn_a),
        .en       (en_a),
        .mode     (mode_a),
`ifdef UNIV_SHREG_ROTATE_EN
        .rot      (rot_a),
`endif
        .sin      (sin_a),
        .pin      (pin_a),
        .sout_r   (sout_r_a),
        .sout_l   (sout_l_a),
        .pout     (pout_a),
        .fill_cnt (fill_a),
        .full     (full_a)
    );

    univ_shift_reg #(.WIDTH(8), .DEPTH(3)) u_dut_b (
        .clk      (clk),
        .rstn     (rstn_b),
        .en       (en_b),
        .mode     (mode_b),
`ifdef UNIV_SHREG_ROTATE_EN
        .rot      (rot_b),
`endif
        .sin      (sin_b),
        .pin      (pin_b),
        .sout_r   (sout_r_b),
        .sout_l   (sout_l_b),
        .pout     (pout_b),
        .fill_cnt (fill_b),
        .full     (full_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One rising edge, then settle before sampling.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rstn_a = 1'b0; en_a = 1'b1; mode_a = 2'b11; pin_a = 4'hA; sin_a = 1'b1;
        tick();
        tests_run++;
        if (pout_a !== 4'h0) begin
            tests_failed++;
            $display("FAIL reset_pout got=%h exp=%h", pout_a, 4'h0);
        end
        tests_run++;
        if (fill_a !== 3'd0 || full_a !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_cnt got fill=%0d full=%b exp fill=0 full=0", fill_a, full_a);
        end
        tests_run++;
        if (sout_r_a !== 1'b0 || sout_l_a !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_sout got r=%b l=%b exp r=0 l=0", sout_r_a, sout_l_a);
        end
    endtask

    task automatic test_siso_right();
        logic [4:0] exp_sout;
        logic [2:0] exp_fill [5];
        exp_sout = 5'b01000;  // bit k = sout_r after edge k+1
        exp_fill = '{3'd1, 3'd2, 3'd3, 3'd4, 3'd4};
        rstn_a = 1'b1; en_a = 1'b1; mode_a = 2'b01;
        for (int k = 0; k < 5; k++) begin
            sin_a = (k == 0) ? 1'b1 : 1'b0;
            tick();
            tests_run++;
            if (sout_r_a !== exp_sout[k] || fill_a !== exp_fill[k]) begin
                tests_failed++;
                $display("FAIL siso_edge%0d got sout_r=%b fill=%0d exp sout_r=%b fill=%0d",
                         k + 1, sout_r_a, fill_a, exp_sout[k], exp_fill[k]);
            end
        end
        tests_run++;
        if (full_a !== 1'b1) begin
            tests_failed++;
            $display("FAIL siso_full got=%b exp=1", full_a);
        end
    endtask

    task automatic test_load_piso();
        logic [3:0] exp_seq;
        exp_seq = 4'b1011;  // bit k = sout_r after load (k=0) and after shift k
        en_a = 1'b1; mode_a = 2'b11; pin_a = 4'hB; sin_a = 1'b0;
        tick();
        mode_a = 2'b01;
        for (int k = 0; k < 4; k++) begin
            tests_run++;
            if (sout_r_a !== exp_seq[k] || fill_a !== 3'd4) begin
                tests_failed++;
                $display("FAIL piso_step%0d got sout_r=%b fill=%0d exp sout_r=%b fill=4",
                         k, sout_r_a, fill_a, exp_seq[k]);
            end
            tick();
        end
        tests_run++;
        if (pout_a !== 4'h0 || fill_a !== 3'd4 || full_a !== 1'b1) begin
            tests_failed++;
            $display("FAIL piso_end got pout=%h fill=%0d full=%b exp pout=0 fill=4 full=1",
                     pout_a, fill_a, full_a);
        end
    endtask

    task automatic test_hold_dir();
        en_a = 1'b1; mode_a = 2'b11; pin_a = 4'h6;
        tick();
        en_a = 1'b0; mode_a = 2'b01; sin_a = 1'b1;
        for (int k = 0; k < 3; k++) begin
            tick();
            tests_run++;
            if (pout_a !== 4'h6) begin
                tests_failed++;
                $display("FAIL hold_en%0d got=%h exp=%h", k, pout_a, 4'h6);
            end
        end
        en_a = 1'b1; mode_a = 2'b10; sin_a = 1'b1;
        tick();
        tests_run++;
        if (pout_a !== 4'hD || sout_l_a !== 1'b1) begin
            tests_failed++;
            $display("FAIL shl got pout=%h sout_l=%b exp pout=d sout_l=1", pout_a, sout_l_a);
        end
        mode_a = 2'b00; sin_a = 1'b0; pin_a = 4'h0;
        tick();
        tests_run++;
        if (pout_a !== 4'hD || fill_a !== 3'd4) begin
            tests_failed++;
            $display("FAIL hold_mode got pout=%h fill=%0d exp pout=d fill=4", pout_a, fill_a);
        end
        // Reverse again: right shift of 1101 with sin=0 gives 0110.
        mode_a = 2'b01;
        tick();
        tests_run++;
        if (pout_a !== 4'h6 || sout_r_a !== 1'b0) begin
            tests_failed++;
            $display("FAIL reverse got pout=%h sout_r=%b exp pout=6 sout_r=0", pout_a, sout_r_a);
        end
        en_a = 1'b0;
    endtask

    task automatic test_mid_reset();
        rstn_b = 1'b0; en_b = 1'b1; mode_b = 2'b00;
        tick();
        rstn_b = 1'b1; mode_b = 2'b11; pin_b = 24'h112233;
        tick();
        tests_run++;
        if (pout_b !== 24'h112233 || fill_b !== 2'd3 || full_b !== 1'b1) begin
            tests_failed++;
            $display("FAIL wide_load got pout=%h fill=%0d full=%b exp pout=112233 fill=3 full=1",
                     pout_b, fill_b, full_b);
        end
        mode_b = 2'b01; sin_b = 8'h00;
        tick();
        tests_run++;
        if (pout_b !== 24'h001122 || sout_r_b !== 8'h22 || fill_b !== 2'd3) begin
            tests_failed++;
            $display("FAIL wide_shr got pout=%h sout_r=%h fill=%0d exp pout=001122 sout_r=22 fill=3",
                     pout_b, sout_r_b, fill_b);
        end
        rstn_b = 1'b0; sin_b = 8'h55;
        tick();
        tests_run++;
        if (pout_b !== 24'h000000 || fill_b !== 2'd0 || full_b !== 1'b0) begin
            tests_failed++;
            $display("FAIL mid_reset got pout=%h fill=%0d full=%b exp pout=0 fill=0 full=0",
                     pout_b, fill_b, full_b);
        end
        rstn_b = 1'b1; sin_b = 8'h44;
        tick();
        tests_run++;
        if (pout_b !== 24'h440000 || sout_l_b !== 8'h44 || fill_b !== 2'd1 || full_b !== 1'b0) begin
            tests_failed++;
            $display("FAIL post_reset_shr got pout=%h sout_l=%h fill=%0d full=%b exp pout=440000 sout_l=44 fill=1 full=0",
                     pout_b, sout_l_b, fill_b, full_b);
        end
        en_b = 1'b0;
    endtask

`ifdef UNIV_SHREG_ROTATE_EN
    task automatic test_rotate();
        logic [3:0] exp_p [4];
        exp_p = '{4'h4, 4'h2, 4'h1, 4'h8};
        en_a = 1'b1; mode_a = 2'b11; pin_a = 4'h8; rot_a = 1'b1;
        tick();
        mode_a = 2'b01; sin_a = 1'b1;
        for (int k = 0; k < 4; k++) begin
            tick();
            tests_run++;
            if (pout_a !== exp_p[k] || fill_a !== 3'd4) begin
                tests_failed++;
                $display("FAIL rotate%0d got pout=%h fill=%0d exp pout=%h fill=4",
                         k, pout_a, fill_a, exp_p[k]);
            end
        end
        // Rotating shifts after reset must not advance the counter.
        rstn_a = 1'b0;
        tick();
        rstn_a = 1'b1; mode_a = 2'b10;
        tick();
        tests_run++;
        if (fill_a !== 3'd0 || pout_a !== 4'h0) begin
            tests_failed++;
            $display("FAIL rotate_cnt got pout=%h fill=%0d exp pout=0 fill=0", pout_a, fill_a);
        end
        rot_a = 1'b0; en_a = 1'b0;
    endtask
`endif

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        rstn_a = 1'b0; en_a = 1'b0; mode_a = 2'b00; sin_a = 1'b0; pin_a = 4'h0;
        rstn_b = 1'b0; en_b = 1'b0; mode_b = 2'b00; sin_b = 8'h00; pin_b = 24'h0;
`ifdef UNIV_SHREG_ROTATE_EN
        rot_a = 1'b0; rot_b = 1'b0;
`endif
        #2;
        test_reset();
        test_siso_right();
        test_load_piso();
        test_hold_dir();
        test_mid_reset();
`ifdef UNIV_SHREG_ROTATE_EN
        test_rotate();
`endif
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule : tb_univ_shift_reg
